mem_lsu: RTL and testbench

//  Load/store initiator between the MEM pipeline stage and the word-wide data memory port.

---
 rtl/mem_lsu_pkg.sv | 42 ++++
 rtl/mem_lsu_align.sv | 47 ++++
 rtl/mem_lsu.sv | 145 ++++++++++++++
 tb/tb_mem_lsu.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared encodings and request bundle for the load/store unit.
// Optional store trace is enabled with LSU_TRACE_EN (see mem_lsu.sv).
package mem_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } lsu_req_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    unique case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering: enables, replicated store data and
// extended load data for one byte/half/word access.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] ext_rdata
);

  logic [31:0] lane;

  always_comb begin
    lane       = rdata >> {off, 3'b000};
    be         = 4'b0000;
    lane_wdata = wdata;
    ext_rdata  = rdata;
    unique case (size)
      SZ_B: begin
        be         = 4'b0001 << off;
        lane_wdata = {4{wdata[7:0]}};
        ext_rdata  = {{24{sext & lane[7]}}, lane[7:0]};
      end
      SZ_H: begin
        be         = 4'b0011 << off;
        lane_wdata = {2{wdata[15:0]}};
        ext_rdata  = {{16{sext & lane[15]}}, lane[15:0]};
      end
      SZ_W: begin
        be         = 4'b1111;
        lane_wdata = wdata;
        ext_rdata  = rdata;
      end
      default: begin
        be         = 4'b0000;
        lane_wdata = wdata;
        ext_rdata  = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: MEM stage to word-wide data memory port.
// Define LSU_TRACE_EN to print every granted store.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_code,
  output logic [31:0] resp_pc,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  lsu_req_t      req_q;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic          exc_q;
  logic [4:0]    code_q;

  logic          bad;
  logic          issue;
  logic [3:0]    be;
  logic [31:0]   lane_wdata;
  logic [31:0]   ext_rdata;

  assign bad = misaligned(req_size, req_addr[1:0])
             | ({2'b00, req_addr[31:2]} >= 32'(RAM_WORDS));

  mem_lsu_align u_align (
    .size       (req_q.size),
    .off        (req_q.addr[1:0]),
    .sext       (req_q.sext),
    .wdata      (req_q.wdata),
    .rdata      (mem_rdata),
    .be         (be),
    .lane_wdata (lane_wdata),
    .ext_rdata  (ext_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      req_q   <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_q   <= '{req_we, req_size, req_signed,
                         req_addr, req_wdata, req_pc};
            rdata_q <= '0;
            exc_q   <= 1'b0;
            code_q  <= '0;
            if (bad) begin
              exc_q  <= 1'b1;
              code_q <= req_we ? EXC_ADES : EXC_ADEL;
              state  <= S_RESP;
            end else begin
              state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mem_gnt) begin
            cnt   <= '0;
            state <= req_q.we ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          // data arriving on the timeout cycle still completes normally
          if (mem_rvalid) begin
            rdata_q <= ext_rdata;
            state   <= S_RESP;
          end else if (cnt == LAST) begin
            exc_q   <= 1'b1;
            code_q  <= EXC_DBE;
            state   <= S_RESP;
          end else begin
            cnt     <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign issue     = (state == S_ISSUE);
  assign req_ready = (state == S_IDLE);

  assign mem_req   = issue;
  assign mem_we    = issue & req_q.we;
  assign mem_addr  = issue ? {req_q.addr[31:2], 2'b00} : '0;
  assign mem_be    = issue ? be : '0;
  assign mem_wdata = issue ? lane_wdata : '0;

  assign resp_valid = (state == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_exc   = resp_valid & exc_q;
  assign resp_code  = resp_valid ? code_q : '0;
  assign resp_pc    = resp_valid ? req_q.pc : '0;

`ifdef LSU_TRACE_EN
  logic [31:0] merged_word;

  assign merged_word = mem_wdata & {{8{mem_be[3]}}, {8{mem_be[2]}},
                                    {8{mem_be[1]}}, {8{mem_be[0]}}};

  always_ff @(posedge clk) begin
    if (reset && mem_req && mem_gnt && mem_we
        && !$isunknown(merged_word))
      $display("%d@%h: *%h <= %h", $time, req_q.pc,
               mem_addr, merged_word);
  end
`else
  // store trace not built
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Directed vector bench for mem_lsu.
module tb_mem_lsu;

  localparam int RW = 4096;
  localparam int TO = 16;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [4:0]  resp_code;
  logic [31:0] resp_pc;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  // 4096 words so that the 0x1001 store example lies in range
  mem_lsu #(.RAM_WORDS(RW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_exc   (resp_exc),
    .resp_code  (resp_code),
    .resp_pc    (resp_pc),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] lane;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wdata,
                       input logic [31:0] pc);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_pc     = pc;
    req_valid  = 1'b1;
    chk("ready_at_accept", {31'b0, req_ready}, 32'd1);
    step();
    req_valid  = 1'b0;
    req_wdata  = 32'h0;
    req_addr   = 32'h0;
  endtask

  task automatic grant();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [31:0] pc;
    int waited;
    logic [31:0] a0, d0;
    logic [3:0] b0;

    vecs[0]  = '{1, 0, 0, 32'h1001, 32'h000000AB, 32'h0,
                 4'b0010, 32'hABABABAB, 0, 5'd0, 32'h0};
    vecs[1]  = '{0, 1, 1, 32'h2002, 32'h0, 32'h80011234,
                 4'b1100, 32'h0, 0, 5'd0, 32'hFFFF8001};
    vecs[2]  = '{0, 1, 0, 32'h2002, 32'h0, 32'h80011234,
                 4'b1100, 32'h0, 0, 5'd0, 32'h00008001};
    vecs[3]  = '{0, 0, 1, 32'h0003, 32'h0, 32'h80FF1234,
                 4'b1000, 32'h0, 0, 5'd0, 32'hFFFFFF80};
    vecs[4]  = '{0, 0, 0, 32'h0001, 32'h0, 32'h123456F0,
                 4'b0010, 32'h0, 0, 5'd0, 32'h00000056};
    vecs[5]  = '{0, 2, 1, 32'h3FFC, 32'h0, 32'hDEADBEEF,
                 4'b1111, 32'h0, 0, 5'd0, 32'hDEADBEEF};
    vecs[6]  = '{1, 1, 0, 32'h0102, 32'h1234CAFE, 32'h0,
                 4'b1100, 32'hCAFECAFE, 0, 5'd0, 32'h0};
    vecs[7]  = '{1, 2, 0, 32'h0010, 32'h89ABCDEF, 32'h0,
                 4'b1111, 32'h89ABCDEF, 0, 5'd0, 32'h0};
    vecs[8]  = '{1, 2, 0, 32'h0006, 32'h11111111, 32'h0,
                 4'b0000, 32'h0, 1, 5'd5, 32'h0};
    vecs[9]  = '{0, 2, 0, 32'h4000, 32'h0, 32'h0,
                 4'b0000, 32'h0, 1, 5'd4, 32'h0};
    vecs[10] = '{0, 1, 1, 32'h0005, 32'h0, 32'h0,
                 4'b0000, 32'h0, 1, 5'd4, 32'h0};
    vecs[11] = '{1, 3, 0, 32'h0000, 32'h5A5A5A5A, 32'h0,
                 4'b0000, 32'h0, 1, 5'd5, 32'h0};

    clk = 0; reset = 0; req_valid = 0; req_we = 0; req_size = 0;
    req_signed = 0; req_addr = 0; req_wdata = 0; req_pc = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

    repeat (2) step();
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset = 1;
    step();

    for (int i = 0; i < 12; i++) begin
      v  = vecs[i];
      pc = 32'h400 + 32'(i) * 4;
      issue(v.we, v.size, v.sgn, v.addr, v.wdata, pc);
      if (v.exc) begin
        chk($sformatf("v%0d_no_mem_req", i), {31'b0, mem_req}, 32'd0);
      end else begin
        chk($sformatf("v%0d_mem_req", i), {31'b0, mem_req}, 32'd1);
        chk($sformatf("v%0d_ready_busy", i), {31'b0, req_ready}, 32'd0);
        chk($sformatf("v%0d_addr", i), mem_addr, {v.addr[31:2], 2'b00});
        chk($sformatf("v%0d_be", i), {28'b0, mem_be}, {28'b0, v.be});
        chk($sformatf("v%0d_we", i), {31'b0, mem_we}, {31'b0, v.we});
        if (v.we)
          chk($sformatf("v%0d_wdata", i), mem_wdata, v.lane);
        grant();
        if (!v.we) begin
          chk($sformatf("v%0d_wait", i), {31'b0, resp_valid}, 32'd0);
          mem_rvalid = 1'b1;
          mem_rdata  = v.rdata;
          step();
          mem_rvalid = 1'b0;
          mem_rdata  = 32'h0;
        end
      end
      chk($sformatf("v%0d_resp_valid", i), {31'b0, resp_valid}, 32'd1);
      chk($sformatf("v%0d_exc", i), {31'b0, resp_exc}, {31'b0, v.exc});
      chk($sformatf("v%0d_code", i), {27'b0, resp_code}, {27'b0, v.code});
      chk($sformatf("v%0d_rdata", i), resp_rdata, v.res);
      chk($sformatf("v%0d_pc", i), resp_pc, pc);
      step();
      chk($sformatf("v%0d_pulse", i), {31'b0, resp_valid}, 32'd0);
      chk($sformatf("v%0d_ready", i), {31'b0, req_ready}, 32'd1);
    end

    // load timeout, then a late rvalid that must be dropped
    issue(0, 2, 0, 32'h0040, 32'h0, 32'h800);
    grant();
    waited = 0;
    while (!resp_valid && waited < 40) begin
      step();
      waited++;
    end
    chk("to_cycles", 32'(waited), 32'(TO));
    chk("to_exc", {31'b0, resp_exc}, 32'd1);
    chk("to_code", {27'b0, resp_code}, 32'd7);
    chk("to_rdata", resp_rdata, 32'd0);
    chk("to_pc", resp_pc, 32'h800);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCCCCCCCC;
    step();
    mem_rvalid = 1'b0;
    chk("late_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("late_ready", {31'b0, req_ready}, 32'd1);
    step();
    chk("late_no_resp2", {31'b0, resp_valid}, 32'd0);

    // rvalid on the very cycle the timeout is reached
    issue(0, 0, 1, 32'h0042, 32'h0, 32'h804);
    grant();
    repeat (TO - 1) step();
    chk("edge_no_resp_yet", {31'b0, resp_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00920000;
    step();
    mem_rvalid = 1'b0;
    chk("edge_resp", {31'b0, resp_valid}, 32'd1);
    chk("edge_exc", {31'b0, resp_exc}, 32'd0);
    chk("edge_rdata", resp_rdata, 32'hFFFFFF92);
    step();

    // grant withheld: request and bus fields must hold
    issue(1, 1, 0, 32'h0206, 32'h0000BEEF, 32'h808);
    a0 = 32'h0204; b0 = 4'b1100; d0 = 32'hBEEFBEEF;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold%0d_req", c), {31'b0, mem_req}, 32'd1);
      chk($sformatf("hold%0d_addr", c), mem_addr, a0);
      chk($sformatf("hold%0d_be", c), {28'b0, mem_be}, {28'b0, b0});
      chk($sformatf("hold%0d_wdata", c), mem_wdata, d0);
      chk($sformatf("hold%0d_ready", c), {31'b0, req_ready}, 32'd0);
      step();
    end
    grant();
    chk("hold_resp", {31'b0, resp_valid}, 32'd1);
    chk("hold_exc", {31'b0, resp_exc}, 32'd0);
    step();

    // reset while waiting for load data
    issue(0, 2, 0, 32'h0080, 32'h0, 32'h80C);
    grant();
    step();
    reset = 0;
    step();
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_resp", {31'b0, resp_valid}, 32'd0);
    chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_pc", resp_pc, 32'd0);
    reset = 1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    step();
    mem_rvalid = 1'b0;
    waited = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) waited++;
      step();
    end
    chk("mid_rst_no_resp", 32'(waited), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
